// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// one-entry result register and saturating per-port accepted-op counters.
module alu_arbiter #(
    parameter int XLEN = 64,
    parameter int CNTW = 32
) (
    input  logic            clock,
    input  logic            reset,

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // A requester holds valid and its fields steady until it sees ready; resp_result
    // stays steady while resp_valid is 1 and resp_ready is 0.
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_sub,
    input  logic            req0_ashr,
    input  logic            req0_w,
    input  logic [2:0]      req0_funct3,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_result,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_sub,
    input  logic            req1_ashr,
    input  logic            req1_w,
    input  logic [2:0]      req1_funct3,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_result,

    output logic            alu_sub,
    output logic            alu_ashr,
    output logic            alu_w,
    output logic [2:0]      alu_funct3,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    input  logic [XLEN-1:0] alu_result,

    output logic [CNTW-1:0] ops0,
    output logic [CNTW-1:0] ops1,

    output logic            dbg_state,
    output logic            dbg_owner,
    output logic            dbg_last_grant
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_next;
    logic            owner;
    logic            last_grant;
    logic [XLEN-1:0] result;
    logic [CNTW-1:0] cnt0;
    logic [CNTW-1:0] cnt1;

    logic            full;
    logic            drain;
    logic            can_accept;
    logic            any_req;
    logic            grant;
    logic            accept;

    assign full       = (state == HELD);
    assign drain      = full & (owner ? resp1_ready : resp0_ready);
    assign can_accept = ~full | drain;
    assign any_req    = req0_valid | req1_valid;
    assign accept     = can_accept & any_req;

    // The turn only moves on an accept, so a waiting port that holds the turn
    // keeps its grant when the other port raises valid.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = can_accept & req0_valid & ~grant;
    assign req1_ready = can_accept & req1_valid & grant;

    // With no request the ALU sees port 0's fields; nothing is captured then.
    always_comb begin
        alu_sub    = req0_sub;
        alu_ashr   = req0_ashr;
        alu_w      = req0_w;
        alu_funct3 = req0_funct3;
        alu_op1    = req0_op1;
        alu_op2    = req0_op2;
        if (grant) begin
            alu_sub    = req1_sub;
            alu_ashr   = req1_ashr;
            alu_w      = req1_w;
            alu_funct3 = req1_funct3;
            alu_op1    = req1_op1;
            alu_op2    = req1_op2;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (accept) begin
                    state_next = HELD;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A drain without accept leaves result/owner untouched; they are masked by full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt0       <= '0;
            cnt1       <= '0;
        end else if (accept) begin
            result     <= alu_result;
            owner      <= grant;
            last_grant <= grant;
            if (!grant && cnt0 != CNT_MAX) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
            if (grant && cnt1 != CNT_MAX) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
        end
    end

    assign resp0_valid  = full & ~owner;
    assign resp1_valid  = full & owner;
    assign resp0_result = result;
    assign resp1_result = result;

    assign ops0 = cnt0;
    assign ops1 = cnt1;

    assign dbg_state      = state;
    assign dbg_owner      = owner;
    assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked against
// a queue-based reference of the round-robin / single-slot behaviour.
module tb_alu_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- main DUT (XLEN=64, CNTW=32) ----------------
    logic        rv[2];
    logic        rsub[2];
    logic        rashr[2];
    logic        rw[2];
    logic [2:0]  rf3[2];
    logic [63:0] ra[2];
    logic [63:0] rb[2];
    logic        pr[2];

    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [63:0] resp0_result, resp1_result;
    logic        a_sub, a_ashr, a_w;
    logic [2:0]  a_f3;
    logic [63:0] a_op1, a_op2, a_res;
    logic [31:0] ops0, ops1;
    logic        dbg_state, dbg_owner, dbg_last_grant;

    // Shared ALU stand-in: RV64 funct3 encoding, W ops sign-extend the low word.
    function automatic logic [63:0] alu_ref(input logic [2:0] f3, input logic sub,
                                            input logic ashr, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic [31:0] lo;
        int unsigned sh;
        sh = w ? {27'd0, b[4:0]} : {26'd0, b[5:0]};
        lo = a[31:0];
        case (f3)
            3'd0: r = sub ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: r = (a < b) ? 64'd1 : 64'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (w) r = {32'd0, ashr ? $unsigned($signed(lo) >>> sh) : (lo >> sh)};
                else   r = ashr ? $unsigned($signed(a) >>> sh) : (a >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        if (w) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    always_comb a_res = alu_ref(a_f3, a_sub, a_ashr, a_w, a_op1, a_op2);

    alu_arbiter #(.XLEN(64), .CNTW(32)) u_dut (
        .clock(clock), .reset(reset),
        .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_sub(rsub[0]), .req0_ashr(rashr[0]),
        .req0_w(rw[0]), .req0_funct3(rf3[0]), .req0_op1(ra[0]), .req0_op2(rb[0]),
        .resp0_valid(resp0_valid), .resp0_ready(pr[0]), .resp0_result(resp0_result),
        .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_sub(rsub[1]), .req1_ashr(rashr[1]),
        .req1_w(rw[1]), .req1_funct3(rf3[1]), .req1_op1(ra[1]), .req1_op2(rb[1]),
        .resp1_valid(resp1_valid), .resp1_ready(pr[1]), .resp1_result(resp1_result),
        .alu_sub(a_sub), .alu_ashr(a_ashr), .alu_w(a_w), .alu_funct3(a_f3),
        .alu_op1(a_op1), .alu_op2(a_op2), .alu_result(a_res),
        .ops0(ops0), .ops1(ops1),
        .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_last_grant(dbg_last_grant)
    );

    // ---------------- saturation DUT (CNTW=2) ----------------
    logic        s_valid, s_ready, s_rv0, s_rr1, s_rv1;
    logic [63:0] s_res0, s_res1;
    logic        s_sub, s_ashr, s_w;
    logic [2:0]  s_f3;
    logic [63:0] s_op1, s_op2, s_ares;
    logic [1:0]  s_ops0, s_ops1;
    logic        s_dbg_state, s_dbg_owner, s_dbg_last;

    always_comb s_ares = alu_ref(s_f3, s_sub, s_ashr, s_w, s_op1, s_op2);

    alu_arbiter #(.XLEN(64), .CNTW(2)) u_sat (
        .clock(clock), .reset(reset),
        .req0_valid(s_valid), .req0_ready(s_ready), .req0_sub(1'b0), .req0_ashr(1'b0),
        .req0_w(1'b0), .req0_funct3(3'd0), .req0_op1(64'd1), .req0_op2(64'd2),
        .resp0_valid(s_rv0), .resp0_ready(1'b1), .resp0_result(s_res0),
        .req1_valid(1'b0), .req1_ready(s_rr1), .req1_sub(1'b0), .req1_ashr(1'b0),
        .req1_w(1'b0), .req1_funct3(3'd0), .req1_op1(64'd0), .req1_op2(64'd0),
        .resp1_valid(s_rv1), .resp1_ready(1'b1), .resp1_result(s_res1),
        .alu_sub(s_sub), .alu_ashr(s_ashr), .alu_w(s_w), .alu_funct3(s_f3),
        .alu_op1(s_op1), .alu_op2(s_op2), .alu_result(s_ares),
        .ops0(s_ops0), .ops1(s_ops1),
        .dbg_state(s_dbg_state), .dbg_owner(s_dbg_owner), .dbg_last_grant(s_dbg_last)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [63:0] exp0_q[$];
    logic [63:0] exp1_q[$];
    int          m_last;
    longint      m_cnt[2];
    logic        acc[2];
    logic        seen_rdy[2];
    localparam longint CNT32_MAX = 64'hFFFF_FFFF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp0_q.delete();
        exp1_q.delete();
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        acc[0]   = 1'b0;
        acc[1]   = 1'b0;
    endtask

    task automatic set_op(input int p, input logic [2:0] f3, input logic sub, input logic ashr,
                          input logic w, input logic [63:0] a, input logic [63:0] b);
        rv[p] = 1'b1; rf3[p] = f3; rsub[p] = sub; rashr[p] = ashr; rw[p] = w;
        ra[p] = a; rb[p] = b;
    endtask

    task automatic rand_op(input int p);
        logic [63:0] a, b;
        a = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
        b = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
        set_op(p, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), a, b);
    endtask

    // One clock: compare outputs at the falling edge, advance the model, end at posedge+1.
    task automatic step();
        logic held, hp, drain, room, any, win;
        @(negedge clock);
        held = (exp0_q.size() + exp1_q.size()) != 0;
        hp   = (exp1_q.size() != 0);
        check("resp0_valid", 64'(resp0_valid), 64'(exp0_q.size() != 0));
        check("resp1_valid", 64'(resp1_valid), 64'(exp1_q.size() != 0));
        if (exp0_q.size() != 0) check("resp0_result", resp0_result, exp0_q[0]);
        if (exp1_q.size() != 0) check("resp1_result", resp1_result, exp1_q[0]);
        drain = held && (hp ? pr[1] : pr[0]);
        room  = !held || drain;
        any   = rv[0] || rv[1];
        if (rv[0] && rv[1]) win = (m_last == 0);
        else                win = rv[1];
        acc[0] = room && any && !win && rv[0];
        acc[1] = room && any && win && rv[1];
        seen_rdy[0] = req0_ready;
        seen_rdy[1] = req1_ready;
        check("req0_ready", 64'(req0_ready), 64'(acc[0]));
        check("req1_ready", 64'(req1_ready), 64'(acc[1]));
        check("ops0", 64'(ops0), 64'(m_cnt[0]));
        check("ops1", 64'(ops1), 64'(m_cnt[1]));
        if (drain) begin
            if (hp) void'(exp1_q.pop_front());
            else    void'(exp0_q.pop_front());
        end
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
                if (p == 0) exp0_q.push_back(alu_ref(rf3[0], rsub[0], rashr[0], rw[0], ra[0], rb[0]));
                else        exp1_q.push_back(alu_ref(rf3[1], rsub[1], rashr[1], rw[1], ra[1], rb[1]));
                m_last = p;
                if (m_cnt[p] < CNT32_MAX) m_cnt[p]++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0; pr[p] = 1'b0;
            set_op(p, 3'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
            rv[p] = 1'b0;
        end
        s_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    logic [1:0] sat_exp[5];

    initial begin
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();

        // Reset state
        check("rst_resp0_valid", 64'(resp0_valid), 64'd0);
        check("rst_resp1_valid", 64'(resp1_valid), 64'd0);
        check("rst_resp0_result", resp0_result, 64'd0);
        check("rst_ops0", 64'(ops0), 64'd0);
        check("rst_ops1", 64'(ops1), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_last_grant", 64'(dbg_last_grant), 64'd1);

        // Reset mid-op: held result vanishes asynchronously
        set_op(0, 3'd0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7);
        step();
        rv[0] = 1'b0;
        check("midop_held", 64'(resp0_valid), 64'd1);
        check("midop_ops0", 64'(ops0), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midop_async_valid", 64'(resp0_valid), 64'd0);
        check("midop_async_ops0", 64'(ops0), 64'd0);
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        set_op(0, 3'd4, 1'b0, 1'b0, 1'b0, 64'h55, 64'h0F);
        set_op(1, 3'd4, 1'b0, 1'b0, 1'b0, 64'hAA, 64'hF0);
        pr[0] = 1'b1; pr[1] = 1'b1;
        step();
        check("midop_tie_g0", 64'(seen_rdy[0]), 64'd1);
        check("midop_tie_g1", 64'(seen_rdy[1]), 64'd0);
        rv[0] = 1'b0;
        step();
        rv[1] = 1'b0;
        step();

        // Single port stream with 1 op/cycle
        do_reset();
        pr[0] = 1'b1;
        set_op(0, 3'd0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7);
        step();
        check("stream_rdy_add", 64'(seen_rdy[0]), 64'd1);
        set_op(0, 3'd0, 1'b1, 1'b0, 1'b0, 64'd5, 64'd7);
        check("stream_add", resp0_result, 64'd12);
        step();
        check("stream_rdy_sub", 64'(seen_rdy[0]), 64'd1);
        set_op(0, 3'd3, 1'b0, 1'b0, 1'b0, 64'd3, 64'd9);
        check("stream_sub", resp0_result, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("stream_rdy_sltu", 64'(seen_rdy[0]), 64'd1);
        rv[0] = 1'b0;
        check("stream_sltu", resp0_result, 64'd1);
        step();
        check("stream_ops0", 64'(ops0), 64'd3);

        // Tie fairness
        do_reset();
        pr[0] = 1'b1; pr[1] = 1'b1;
        rand_op(0); rf3[0] = 3'd4; rw[0] = 1'b0;
        rand_op(1); rf3[1] = 3'd4; rw[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("tie_grant", {62'd0, seen_rdy[1], seen_rdy[0]}, (i % 2 == 1) ? 64'd2 : 64'd1);
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    rand_op(p); rf3[p] = 3'd4; rw[p] = 1'b0;
                end
            end
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        step();
        check("tie_ops0", 64'(ops0), 64'd4);
        check("tie_ops1", 64'(ops1), 64'd4);

        // Backpressure on port 1, port 0 waiting
        do_reset();
        set_op(1, 3'd7, 1'b0, 1'b0, 1'b0, 64'hF0, 64'h3C);
        step();
        rv[1] = 1'b0;
        set_op(0, 3'd0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd23);
        pr[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_req0_ready", 64'(seen_rdy[0]), 64'd0);
            check("bp_req1_ready", 64'(seen_rdy[1]), 64'd0);
            check("bp_resp1_valid", 64'(resp1_valid), 64'd1);
            check("bp_resp1_result", resp1_result, 64'h30);
        end
        pr[1] = 1'b1;
        step();
        check("bp_same_cycle_accept", 64'(seen_rdy[0]), 64'd1);
        rv[0] = 1'b0; pr[1] = 1'b0;
        check("bp_resp0_result", resp0_result, 64'd123);
        check("bp_resp1_dropped", 64'(resp1_valid), 64'd0);
        step();

        // W-op passthrough
        do_reset();
        set_op(1, 3'd1, 1'b0, 1'b0, 1'b1, 64'd1, 64'd31);
        step();
        rv[1] = 1'b0;
        check("w_sllw", resp1_result, 64'hFFFF_FFFF_8000_0000);
        pr[1] = 1'b1;
        step();

        // Counter saturation on the CNTW=2 instance
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("sat_ready", 64'(s_ready), 64'd1);
            @(posedge clock);
            #1;
            check("sat_ops0", 64'(s_ops0), 64'(sat_exp[i]));
        end
        s_valid = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rv[p] || acc[p]) begin
                    if ($urandom_range(0, 3) != 0) rand_op(p);
                    else rv[p] = 1'b0;
                end
                pr[p] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) rv[p] = 1'b0;
        end
        pr[0] = 1'b1; pr[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) rv[p] = 1'b0;
            end
            step();
        end
        check("rand_drained", 64'(exp0_q.size() + exp1_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance (XLEN-wide, funct3/sub/ashr/w op encoding) between two requesters: port 0 (execute stage) and port 1 (address-gen/CSR helper).
- Round-robin grant, one-entry registered result per accepted op, valid/ready handshakes on both request and response sides.
- Per-port saturating op counters for performance monitoring.

Parameters:
- XLEN, 64, datapath width; must match the shared ALU.
- CNTW, 32, width of per-port op counters.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  port 0 op present
- req0_ready  out  1  port 0 op accepted this cycle
- req0_sub, req0_ashr, req0_w  in  1 each  ALU control for port 0
- req0_funct3  in  3  ALU function for port 0
- req0_op1, req0_op2  in  XLEN  operands for port 0
- resp0_valid  out  1  port 0 result held
- resp0_ready  in  1  port 0 consumes result
- resp0_result  out  XLEN  port 0 result
- req1_*, resp1_*  same as port 0, for port 1
- alu_sub, alu_ashr, alu_w  out  1 each  to shared ALU
- alu_funct3  out  3  to shared ALU
- alu_op1, alu_op2  out  XLEN  to shared ALU
- alu_result  in  XLEN  from shared ALU, combinational in the same cycle
- ops0, ops1  out  CNTW  accepted-op counts, saturating

Behaviour:
- Reset (reset low, asynchronous): resp0_valid=0, resp1_valid=0, result regs=0, owner=0, last_grant=1 (so port 0 wins first tie), ops0=ops1=0. Outputs hold while reset is low. Any in-flight result is discarded.
- Storage: one result register, one owner bit, one full flag.
  - States: EMPTY (full=0) and HELD (full=1).
  - respN_valid = full & (owner==N); respN_result = result reg. The other port's resp_valid is 0.
- Drain: drain = full & resp[owner]_ready.
- Accept window: can_accept = !full | drain. A held result consumed this cycle allows a new op in the same cycle, giving 1 op/cycle throughput.
- Grant (combinational):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant !last_grant.
  - Neither valid: no grant.
- reqN_ready = can_accept & grant==N & reqN_valid. The ungranted port's ready is 0.
- ALU drive: alu_* = fields of the granted port. With no grant, fields of port 0. Outputs are purely combinational from requester inputs; no extra state.
- On accept (rising edge):
  - result <= alu_result; owner <= grant; full <= 1; last_grant <= grant; opsN++ unless at all-ones (saturate).
  - Latency: result visible on respN the cycle after acceptance.
- Drain without accept: full <= 0. Owner and result are retained but unused.
- Simultaneous drain + accept: new result replaces old one in the same edge; full stays 1; owner may switch ports.
- last_grant updates only on accept, never on a mere valid.
- Requester rules:
  - reqN_* fields must be stable while reqN_valid=1 and not accepted.
  - Requester may not drop valid before ready.
  - Arbiter must not change grant away from a valid, unaccepted port solely because the other port raised valid, when that port already holds the round-robin turn.
- Response rules: respN_result is stable while respN_valid=1 and not consumed.
- Width rules: result register is XLEN bits; W-op sign extension is done inside the ALU; the arbiter passes alu_result unmodified.
- Counters wrap never; they stick at 2^CNTW-1.
- X-safety: no output is X after reset deasserts, even with ALU default-case X. An unused funct3 result is stored as-is; the arbiter is not responsible for it.

Test Plan:
- Reset mid-op: accept port 0 ADD, then assert reset low before resp0_ready -> resp0_valid drops to 0 immediately (asynchronous); ops0=0; after release the first tie grants port 0.
- Single port stream: port 0 sends ADD 5+7, SUB 5-7, SLTU 3<9 back-to-back with resp0_ready=1 -> req0_ready=1 every cycle; resp0_result = 12, 0xFFFF_FFFF_FFFF_FFFE, 1 on consecutive cycles; ops0=3.
- Tie fairness: both ports valid continuously with XOR ops, both resp_ready=1 -> grants alternate 0,1,0,1; results appear on resp0/resp1 alternately; ops0=ops1 after an even count.
- Backpressure: port 1 AND 0xF0 & 0x3C accepted with resp1_ready=0 for 3 cycles -> resp1_valid=1, resp1_result=0x30 stable; req0_ready=0 and req1_ready=0 for those cycles. On the ready cycle a pending port 0 op is accepted in the same cycle.
- W-op passthrough: port 1 SLL with w=1, op1=1, op2=31 -> resp1_result=0xFFFF_FFFF_8000_0000.
- Counter saturation with CNTW=2: accept 5 ops on port 0 -> ops0 reads 1,2,3,3,3.
